// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared constants, scan-state encoding and BCD helper for the
//            detector count/display block.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int unsigned c_SCAN_DIV_DEFAULT = 4;

    typedef enum logic [0:0] {
        DIG_LO = 1'b0,
        DIG_HI = 1'b1
    } scan_state_t;

    // Active-high {g,f,e,d,c,b,a}; entry [0] is digit 0.
    localparam logic [9:0][6:0] c_SEG_PATTERNS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    localparam logic [1:0] c_AN_UNITS = 2'b10;
    localparam logic [1:0] c_AN_TENS  = 2'b01;

    typedef struct packed {
        logic [7:0] cnt;
        logic       wrap;
    } bcd_inc_t;

    // Two-digit BCD increment; wrap flags the 99 -> 00 rollover.
    function automatic bcd_inc_t bcd_inc(input logic [7:0] cnt);
        bcd_inc_t res;
        res.cnt  = cnt;
        res.wrap = 1'b0;
        if (cnt[3:0] >= 4'd9) begin
            res.cnt[3:0] = 4'd0;
            if (cnt[7:4] >= 4'd9) begin
                res.cnt[7:4] = 4'd0;
                res.wrap     = 1'b1;
            end else begin
                res.cnt[7:4] = cnt[7:4] + 4'd1;
            end
        end else begin
            res.cnt[3:0] = cnt[3:0] + 4'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg
// Brief    : Combinational BCD digit to 7-segment decoder; non-BCD codes blank.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import seq_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = c_SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = c_SEG_PATTERNS[bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/det_count_disp.sv
`default_nettype none
// ============================================================================
// Module   : det_count_disp
// Brief    : Counts rising edges of a detector output as two BCD digits with a
//            sticky wrap flag, and scans them onto a 2-digit 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module det_count_disp
    import seq_pkg::*;
#(
    parameter int unsigned SCAN_DIV = c_SCAN_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_in,
    input  logic       clr,
    input  logic       hold,
    output logic [7:0] cnt_bcd,
    output logic       ovf,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned         c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

    logic                r_det_q;
    logic                w_rise;
    logic [7:0]          r_cnt;
    logic                r_ovf;
    bcd_inc_t            w_inc;
    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic                w_scan_done;
    logic [3:0]          w_digit;
    logic [6:0]          w_seg;
    logic [6:0]          r_seg;
    logic [1:0]          r_an;

    assign w_rise = det_in & ~r_det_q;
    assign w_inc  = bcd_inc(r_cnt);

    // det_q tracks det_in even during hold, so a level spanning hold release is not a new event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_det_q <= 1'b0;
            r_cnt   <= 8'h00;
            r_ovf   <= 1'b0;
        end else begin
            r_det_q <= det_in;
            if (clr) begin
                r_cnt <= 8'h00;
                r_ovf <= 1'b0;
            end else if (!hold && w_rise) begin
                r_cnt <= w_inc.cnt;
                if (w_inc.wrap) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign w_scan_done = (r_scan_cnt == c_SCAN_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
        end else if (w_scan_done) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DIG_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_scan_done) begin
            w_state_next = (r_state == DIG_LO) ? DIG_HI : DIG_LO;
        end
    end

    // Digit is picked by the upcoming state so the registered seg and an stay aligned.
    assign w_digit = (w_state_next == DIG_LO) ? r_cnt[3:0] : r_cnt[7:4];

    bcd_to_seg u_bcd_to_seg (
        .bcd (w_digit),
        .seg (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= c_SEG_PATTERNS[0];
            r_an  <= c_AN_UNITS;
        end else begin
            r_seg <= w_seg;
            r_an  <= (w_state_next == DIG_LO) ? c_AN_UNITS : c_AN_TENS;
        end
    end

    assign cnt_bcd = r_cnt;
    assign ovf     = r_ovf;
    assign seg     = r_seg;
    assign an      = r_an;

endmodule
`default_nettype wire

// File: tb/tb_det_count_disp.sv
`default_nettype none
// ============================================================================
// Module   : tb_det_count_disp
// Brief    : Self-checking bench for det_count_disp (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_det_count_disp;

    logic       clk = 1'b0;
    logic       reset;
    logic       det_in;
    logic       clr;
    logic       hold;
    logic [7:0] cnt_bcd;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] an;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       det;
        logic       clr;
        logic       hold;
        logic [7:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    det_count_disp #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .det_in  (det_in),
        .clr     (clr),
        .hold    (hold),
        .cnt_bcd (cnt_bcd),
        .ovf     (ovf),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic d, input logic c, input logic h,
                       input logic [7:0] cnt, input logic o);
        vec_t v;
        v.det  = d;
        v.clr  = c;
        v.hold = h;
        v.cnt  = cnt;
        v.ovf  = o;
        vecs.push_back(v);
    endtask

    task automatic check_display(input logic [7:0] exp_cnt);
        check("an_onehot", 32'(an == 2'b10 || an == 2'b01), 32'd1);
        if (an == 2'b10) check("seg_units", 32'(seg), 32'(seg_of(exp_cnt[3:0])));
        else             check("seg_tens",  32'(seg), 32'(seg_of(exp_cnt[7:4])));
    endtask

    // Called right after reset release; count is 00 so every digit shows 3F.
    task automatic scan_check();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            check("scan_an", 32'(an), ((k / 4) % 2 == 0) ? 32'h2 : 32'h1);
            check("scan_seg", 32'(seg), 32'h3F);
        end
    endtask

    logic [7:0] lfsr;
    logic [7:0] pat;
    logic [2:0] sh;
    logic       src;
    logic       prev;
    int         edges;
    int         exp_n;
    logic       exp_ovf;

    initial begin
        reset  = 1'b1;
        det_in = 1'b0;
        clr    = 1'b0;
        hold   = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_async_cnt", 32'(cnt_bcd), 32'h00);
        check("rst_async_an",  32'(an),      32'h2);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", 32'(cnt_bcd), 32'h00);
        check("rst_ovf", 32'(ovf),     32'h0);
        check("rst_an",  32'(an),      32'h2);
        check("rst_seg", 32'(seg),     32'h3F);
        reset = 1'b1;
        scan_check();

        // det, clr, hold -> cnt, ovf after the edge
        add(1, 0, 0, 8'h01, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h01, 0);
        add(0, 0, 0, 8'h01, 0);
        add(0, 0, 0, 8'h01, 0);
        add(1, 0, 0, 8'h02, 0);
        add(0, 0, 0, 8'h02, 0);
        add(1, 0, 0, 8'h03, 0);
        add(0, 0, 0, 8'h03, 0);
        add(1, 0, 0, 8'h04, 0);
        add(0, 0, 0, 8'h04, 0);
        add(1, 0, 1, 8'h04, 0);
        add(0, 0, 1, 8'h04, 0);
        add(1, 0, 1, 8'h04, 0);
        add(0, 0, 1, 8'h04, 0);
        add(1, 0, 1, 8'h04, 0);
        add(1, 0, 0, 8'h04, 0);
        add(0, 0, 0, 8'h04, 0);
        add(1, 0, 0, 8'h05, 0);
        add(1, 1, 1, 8'h00, 0);
        add(0, 0, 0, 8'h00, 0);
        add(1, 0, 0, 8'h01, 0);
        add(0, 0, 0, 8'h01, 0);
        add(0, 1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            det_in = vecs[i].det;
            clr    = vecs[i].clr;
            hold   = vecs[i].hold;
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(cnt_bcd), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_ovf", i), 32'(ovf),     32'(vecs[i].ovf));
        end
        det_in = 1'b0;
        clr    = 1'b0;
        hold   = 1'b0;
        tick();

        // 100 single-cycle pulses: covers 09->10 and the 99->00 wrap.
        exp_n   = 0;
        exp_ovf = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            det_in = 1'b1;
            tick();
            exp_n = (exp_n + 1) % 100;
            if (i == 100) exp_ovf = 1'b1;
            check("pulse_cnt", 32'(cnt_bcd), 32'(to_bcd(exp_n)));
            check("pulse_ovf", 32'(ovf),     32'(exp_ovf));
            det_in = 1'b0;
            tick();
        end
        check("wrap_cnt", 32'(cnt_bcd), 32'h00);
        check("wrap_ovf", 32'(ovf),     32'h1);

        for (int i = 0; i < 42; i++) begin
            det_in = 1'b1;
            tick();
            det_in = 1'b0;
            tick();
        end
        check("cnt42",        32'(cnt_bcd), 32'h42);
        check("ovf_sticky",   32'(ovf),     32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_display(8'h42);
        end

        det_in = 1'b1;
        clr    = 1'b1;
        tick();
        check("clr_rise_cnt", 32'(cnt_bcd), 32'h00);
        check("clr_rise_ovf", 32'(ovf),     32'h0);
        det_in = 1'b0;
        clr    = 1'b0;
        tick();
        check("clr_after_cnt", 32'(cnt_bcd), 32'h00);

        // Detector-chain stand-in: LFSR source, fixed pattern after t=51, "101" match.
        lfsr  = 8'hA5;
        pat   = 8'b1011_0010;
        sh    = 3'b000;
        prev  = 1'b0;
        edges = 0;
        for (int t = 0; t < 100; t++) begin
            if (t < 51) src = lfsr[0];
            else        src = pat[3'(t % 8)];
            lfsr   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            sh     = {sh[1:0], src};
            det_in = (sh == 3'b101);
            if (det_in && !prev) edges++;
            prev = det_in;
            tick();
            check("chain_cnt", 32'(cnt_bcd), 32'(to_bcd(edges % 100)));
        end
        det_in = 1'b0;
        tick();
        tick();
        check("chain_final", 32'(cnt_bcd), 32'(to_bcd(edges % 100)));
        check("chain_ovf",   32'(ovf),     32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_display(to_bcd(edges % 100));
        end

        // Reset mid-cycle while counting/scanning, then a full scan restart.
        tick();
        tick();
        #3 reset = 1'b0;
        #1;
        check("midrst_cnt", 32'(cnt_bcd), 32'h00);
        check("midrst_ovf", 32'(ovf),     32'h0);
        check("midrst_an",  32'(an),      32'h2);
        check("midrst_seg", 32'(seg),     32'h3F);
        tick();
        reset = 1'b1;
        scan_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/det_count_disp.md
DET_COUNT_DISP -- requirements
Module: det_count_disp

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per displayed digit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port det_in  input  1  pulse/level output of seq_detector.
REQ-005 SHALL have port clr  input  1  synchronous clear of count and overflow flag.
REQ-006 SHALL have port hold  input  1  freezes the count while high.
REQ-007 SHALL have port cnt_bcd  output  8  count as two BCD digits; [7:4] tens, [3:0] units.
REQ-008 SHALL have port ovf  output  1  sticky wrap flag.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-010 SHALL have port an  output  2  digit enable, one-hot active-low; an[0] units, an[1] tens.

Function
REQ-011 SHALL register det_in into det_q every cycle; rise = det_in & ~det_q.
REQ-012 SHALL increment the count at the same edge at which rise is sampled true, so cnt_bcd changes 1 cycle after det_in goes high.
REQ-013 SHALL count one event per high run of det_in, regardless of run length; back-to-back 1-0-1 patterns SHALL count twice.
REQ-014 SHALL increment in BCD: units 9 -> 0 with tens +1; no digit SHALL ever hold a value above 9.
REQ-015 SHALL wrap 99 -> 00 on an increment and set ovf at that same edge; ovf SHALL stay high until clr or reset.
REQ-016 SHALL, while clr is high, load count 00 and ovf 0 at each edge; clr SHALL have priority over hold and rise.
REQ-017 SHALL, while hold is high and clr is low, keep the count unchanged and discard rises.
REQ-018 SHALL keep updating det_q during hold, so a level high across hold release does not count.
REQ-019 SHALL run a 2-state scan FSM, DIG_LO (an=2'b10, seg = units) and DIG_HI (an=2'b01, seg = tens).
REQ-020 SHALL move the FSM to the other state after SCAN_DIV cycles in the current state, using a scan counter of width clog2(SCAN_DIV).
REQ-021 SHALL register seg and an so that both change on the same edge; an SHALL never have both bits low.
REQ-022 SHALL use decoder patterns 0 = 7'h3F, 1 = 7'h06, ... 9 = 7'h6F.
REQ-023 SHALL let seg follow the count within 1 cycle of any count change while the corresponding digit is displayed.

Reset
REQ-024 SHALL, while reset is low, asynchronously force the following: cnt_bcd = 8'h00, ovf = 0, det_q = 0, scan counter = 0, FSM = DIG_LO, an = 2'b10, seg = 7'h3F.
REQ-025 SHALL have no count effect from a det_in high at reset release until det_in has been seen low, except a rise first sampled after release.
REQ-026 SHALL, after reset asserted mid-scan or mid-count, restart the scan from DIG_LO with a full SCAN_DIV period.

Structure
REQ-027 SHALL take the segment pattern constants, FSM state encoding (DIG_LO = 0, DIG_HI = 1) and default SCAN_DIV from shared package seq_pkg.
REQ-028 SHALL place the BCD-to-7-segment conversion in one combinational sub-module, bcd_to_seg (4-bit in, 7-bit out), instantiated once after the digit mux.

Verification
REQ-029 Bench SHALL hold reset low for 3 cycles and then release -> cnt_bcd 00, ovf 0, an 10, seg 3F, with an toggling every 4 cycles.
REQ-030 Bench SHALL drive det_in high for 5 cycles, low for 2, then high for 1 -> cnt_bcd 01, then 02, each changing 1 cycle after the rise.
REQ-031 Bench SHALL apply 100 single-cycle pulses spaced 2 cycles apart -> sequence 09 -> 10, 99 -> 00, ovf rising on the 100th pulse and staying high.
REQ-032 Bench SHALL raise hold during 3 pulses and then release while det_in is high -> count unchanged and no extra count.
REQ-033 Bench SHALL assert clr in the same cycle as a rise, at count 42 -> count 00, ovf 0.
REQ-034 Bench SHALL run the seq_gen1/seq_sel/seq_detector chain with sel switched at t = 51 -> count equals the number of detector_out rising edges, with the seg/an scan matching the decoded digits.
